// File: rtl/battle_pkg.sv
// Shared phase codes and widths for the battle screen controller.
package battle_pkg;

  typedef logic [3:0] phase_t;

  localparam phase_t ST_BOOT   = 4'b1010;
  localparam phase_t ST_MENU   = 4'b0001;
  localparam phase_t ST_PLAYER = 4'b0010;
  localparam phase_t ST_ENEMY  = 4'b1000;
  localparam phase_t ST_WIN    = 4'b0100;
  localparam phase_t ST_LOSE   = 4'b0101;

  localparam int HP_W = 8;

endpackage

// File: rtl/battle_sequencer_sat_sub.sv
// Saturating subtractor: y = a - b, clamped at zero; zero_o flags an empty result.
module sat_sub #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] y_o,
  output logic         zero_o
);

  // Compare before subtracting so the result never wraps.
  always_comb begin
    if (a_i > b_i) begin
      y_o = a_i - b_i;
    end else begin
      y_o = '0;
    end
  end

  assign zero_o = (y_o == '0);

endmodule

// File: rtl/battle_sequencer.sv
// Battle turn/phase controller; initiates the enemy phase and waits on the enemy block.
module battle_sequencer
  import battle_pkg::*;
#(
  parameter int PLAYER_HP   = 20,
  parameter int ENEMY_HP    = 30,
  parameter int ATTACK_DMG  = 5,
  parameter int HIT_DMG     = 1,
  parameter int MAX_TURN    = 8,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_in,
  input  logic            attack_in,
  input  logic            hit_in,
  input  logic            enemy_busy_in,
  input  logic            enemy_finished_in,
  output logic [3:0]      state_out,
  output logic [3:0]      turn_out,
  output logic [HP_W-1:0] player_hp_out,
  output logic [HP_W-1:0] enemy_hp_out,
  output logic            phase_start_out,
  output logic            error_out
);

  localparam int WD_W = $clog2(ACK_TIMEOUT + 1);

  localparam logic [HP_W-1:0] PLAYER_HP_C  = HP_W'(PLAYER_HP);
  localparam logic [HP_W-1:0] ENEMY_HP_C   = HP_W'(ENEMY_HP);
  localparam logic [HP_W-1:0] ATTACK_DMG_C = HP_W'(ATTACK_DMG);
  localparam logic [HP_W-1:0] HIT_DMG_C    = HP_W'(HIT_DMG);
  localparam logic [3:0]      MAX_TURN_C   = 4'(MAX_TURN);
  localparam logic [WD_W-1:0] TIMEOUT_C    = WD_W'(ACK_TIMEOUT);

  phase_t          state_q, state_d;
  logic [3:0]      turn_q, turn_d;
  logic [HP_W-1:0] player_hp_q, player_hp_d;
  logic [HP_W-1:0] enemy_hp_q, enemy_hp_d;
  logic            phase_start_q;
  logic            error_q, error_d;
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            busy_seen_q, busy_seen_d;

  logic [HP_W-1:0] enemy_hp_sub;
  logic            enemy_hp_zero;
  logic [HP_W-1:0] player_hp_sub;
  logic            player_hp_zero;
  logic [3:0]      turn_inc;
  logic [WD_W-1:0] wd_inc;

  sat_sub #(.W(HP_W)) u_enemy_sub (
    .a_i    (enemy_hp_q),
    .b_i    (ATTACK_DMG_C),
    .y_o    (enemy_hp_sub),
    .zero_o (enemy_hp_zero)
  );

  sat_sub #(.W(HP_W)) u_player_sub (
    .a_i    (player_hp_q),
    .b_i    (HIT_DMG_C),
    .y_o    (player_hp_sub),
    .zero_o (player_hp_zero)
  );

  assign turn_inc = turn_q + 4'd1;
  assign wd_inc   = wd_cnt_q + WD_W'(1);

  // Next-state and datapath decisions for the current phase.
  always_comb begin
    state_d     = state_q;
    turn_d      = turn_q;
    player_hp_d = player_hp_q;
    enemy_hp_d  = enemy_hp_q;
    error_d     = error_q;
    wd_cnt_d    = wd_cnt_q;
    busy_seen_d = busy_seen_q;
    case (state_q)
      ST_BOOT: state_d = ST_MENU;
      ST_MENU: begin
        if (start_in) begin
          state_d     = ST_PLAYER;
          turn_d      = 4'd0;
          player_hp_d = PLAYER_HP_C;
          enemy_hp_d  = ENEMY_HP_C;
        end
      end
      ST_PLAYER: begin
        if (attack_in) begin
          enemy_hp_d  = enemy_hp_sub;
          wd_cnt_d    = '0;
          busy_seen_d = 1'b0;
          state_d     = enemy_hp_zero ? ST_WIN : ST_ENEMY;
        end
      end
      ST_ENEMY: begin
        // A hit is applied before any finish in the same cycle; dying wins over finishing.
        if (hit_in) begin
          player_hp_d = player_hp_sub;
        end
        if (hit_in && player_hp_zero) begin
          state_d = ST_LOSE;
        end else if (enemy_finished_in) begin
          turn_d  = turn_inc;
          state_d = (turn_inc == MAX_TURN_C) ? ST_WIN : ST_PLAYER;
        end else if (!busy_seen_q) begin
          if (enemy_busy_in) begin
            busy_seen_d = 1'b1;
          end else begin
            wd_cnt_d = wd_inc;
            if (wd_inc == TIMEOUT_C) begin
              error_d = 1'b1;
              state_d = ST_MENU;
            end
          end
        end
      end
      ST_WIN, ST_LOSE: begin
        if (start_in) begin
          state_d = ST_MENU;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  // Phase register, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_BOOT;
      turn_q        <= 4'd0;
      player_hp_q   <= PLAYER_HP_C;
      enemy_hp_q    <= ENEMY_HP_C;
      phase_start_q <= 1'b0;
      error_q       <= 1'b0;
      wd_cnt_q      <= '0;
      busy_seen_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      turn_q        <= turn_d;
      player_hp_q   <= player_hp_d;
      enemy_hp_q    <= enemy_hp_d;
      phase_start_q <= (state_d != state_q);
      error_q       <= error_d;
      wd_cnt_q      <= wd_cnt_d;
      busy_seen_q   <= busy_seen_d;
    end
  end

  assign state_out       = state_q;
  assign turn_out        = turn_q;
  assign player_hp_out   = player_hp_q;
  assign enemy_hp_out    = enemy_hp_q;
  assign phase_start_out = phase_start_q;
  assign error_out       = error_q;

endmodule

// File: doc/battle_sequencer.md
Name: battle_sequencer

Overview:
Top-level turn/phase controller for the battle screen, and the initiator side of the enemy-phase handshake. It drives state_out and turn_out into the enemy attack block and waits for that block's busy/finished response. It tracks player HP, enemy HP and the turn count, and decides WIN/LOSE. It sits between input debouncers (buttons, camera hit detect) and the enemy/render blocks.

Parameters:
PLAYER_HP, 20, initial player HP (8-bit).
ENEMY_HP, 30, initial enemy HP (8-bit).
ATTACK_DMG, 5, enemy HP removed per attack_in in the PLAYER phase.
HIT_DMG, 1, player HP removed per hit_in in the ENEMY phase.
MAX_TURN, 8, number of completed enemy phases before an automatic WIN.
ACK_TIMEOUT, 16, cycles allowed for enemy_busy_in to rise after entering ENEMY.

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
start_in  in  1  one-cycle pulse, start/restart button
attack_in  in  1  one-cycle pulse, player attack
hit_in  in  1  one-cycle pulse, arrow hit the player
enemy_busy_in  in  1  enemy block busy level
enemy_finished_in  in  1  enemy block one-cycle done pulse
state_out  out  4  current phase code (package constants)
turn_out  out  4  turn index, selects the enemy pattern
player_hp_out  out  8  player HP
enemy_hp_out  out  8  enemy HP
phase_start_out  out  1  one-cycle pulse on every state_out change
error_out  out  1  sticky; enemy acknowledge timeout occurred

Behaviour:
- Reset values: state_out=ST_BOOT (4'b1010), turn_out=0, player_hp_out=PLAYER_HP, enemy_hp_out=ENEMY_HP, phase_start_out=0, error_out=0. The timeout counter resets to 0.
- All outputs are registered. state_out changes one cycle after the triggering input. phase_start_out is high in the same cycle state_out first shows the new value.
- State transitions:
  - BOOT -> MENU unconditionally on the first cycle after reset.
  - MENU: on start_in -> PLAYER; HP and turn reload to their initial values in the same cycle.
  - PLAYER: on attack_in, enemy_hp -= ATTACK_DMG, saturating at 0. If the result is 0 -> WIN; otherwise -> ENEMY.
  - ENEMY (4'b1000): state_out holds 4'b1000 until enemy_finished_in. On enemy_finished_in, turn += 1. If the new turn equals MAX_TURN -> WIN; otherwise -> PLAYER.
  - hit_in while in ENEMY: player_hp -= HIT_DMG, saturating at 0. Reaching 0 -> LOSE immediately; the enemy block is not waited on.
  - WIN/LOSE: on start_in -> MENU.
- ENEMY is only ever entered from PLAYER. This guarantees state_out leaves 4'b1000 for at least one cycle between enemy phases, so the enemy block sees a fresh edge each time.
- Acknowledge watchdog:
  - The counter clears on entry to ENEMY and counts while enemy_busy_in=0 and finished has not been seen.
  - Once busy is seen, the watchdog is disarmed for the rest of the phase.
  - If the count reaches ACK_TIMEOUT: error_out<=1 (sticky until rst), state -> MENU.
- Simultaneous events:
  - hit_in and enemy_finished_in in the same cycle: the hit is applied first. If HP reaches 0 -> LOSE; otherwise the normal finish path runs with the updated HP.
  - attack_in outside PLAYER, hit_in outside ENEMY, and start_in outside MENU/WIN/LOSE are ignored.
  - A late enemy_finished_in arriving in LOSE/MENU is ignored.
- Arithmetic: turn is a 4-bit counter and never exceeds MAX_TURN (MAX_TURN <= 15). HP subtraction compares before subtracting; there is no underflow wrap.
- rst in mid-phase returns to ST_BOOT on the next edge, regardless of the enemy block's state.

Decomposition:
- Package battle_pkg holds:
  - phase codes ST_BOOT=4'b1010, ST_MENU=4'b0001, ST_PLAYER=4'b0010, ST_ENEMY=4'b1000, ST_WIN=4'b0100, ST_LOSE=4'b0101;
  - typedef phase_t (logic[3:0]);
  - HP width constant HP_W=8.
- One sub-module: sat_sub (parameterised-width saturating subtractor), instantiated for both HP counters.

Test Plan:
- Reset then idle 3 cycles -> state_out BOOT then MENU at cycle 1; phase_start_out pulses once; HP=20/30, turn=0.
- start_in, then attack_in -> PLAYER, then ENEMY (4'b1000), enemy_hp=25. Bench raises busy at +3 cycles and pulses finished at +100 -> state PLAYER, turn=1, error_out=0.
- Loop 8 full turns with enemy_hp kept >0 (ENEMY_HP=100 override) -> after the 8th finished, state=WIN, turn=8.
- 20 hit_in pulses in ENEMY, with the 20th coincident with enemy_finished_in -> player_hp=0, state=LOSE, turn not incremented.
- Enter ENEMY and never raise busy -> at cycle 16, error_out=1, state=MENU. error_out persists through the next start_in; it clears only on rst.
- Assert rst mid-ENEMY, and in a separate run drive attack_in during ENEMY -> the reset case returns to BOOT with all outputs at reset values; the attack_in case changes nothing.
